// File: rtl/vga_fb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA constants (screen geometry, framebuffer size)
//                and the scanout arbiter state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;

    // 640 x 480 pixels at 4 pixels per 16-bit word
    localparam int FB_WORDS     = 76800;
    localparam int PIX_PER_WORD = 4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_arbiter_if
//  Description : Host write port plus single-port SRAM bus. The arbiter
//                side is "master"; the host/SRAM side is "slave".
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
);
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  host_req, host_addr, host_wdata, mem_rdata,
        output host_gnt, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output host_req, host_addr, host_wdata, mem_rdata,
        input  host_gnt, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/vga_fb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vga_word_fifo
//  Description : Small synchronous word FIFO with push, pop, flush and an
//                occupancy count. Flush wins over a simultaneous push/pop.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_word_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != c_depth) || w_pop);

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_arbiter
//  Description : Shares one single-port framebuffer SRAM between VGA
//                scanout prefetch and a host write port, and serialises
//                fetched words into one 4-bit pixel per pixel slot.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int H_TOTAL    = vga_pkg::H_TOTAL,
    parameter int V_TOTAL    = vga_pkg::V_TOTAL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pixel_en,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    vga_fb_arbiter_if.master        bus,
    output logic [3:0]              pix_data,
    output logic                    underrun
);
    import vga_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = $clog2(PIX_PER_WORD);

    localparam logic [CNT_W:0]    c_depth     = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W:0]    c_urgent    = (CNT_W + 1)'(2);
    localparam logic [ADDR_W-1:0] c_fb_words  = ADDR_W'(FB_WORDS);
    localparam logic [9:0]        c_h_active  = 10'(H_ACTIVE);
    localparam logic [9:0]        c_v_active  = 10'(V_ACTIVE);
    localparam logic [9:0]        c_h_last    = 10'(H_TOTAL - 1);
    localparam logic [9:0]        c_v_last    = 10'(V_TOTAL - 1);
    localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(PIX_PER_WORD - 1);

    arb_state_t         r_state;
    logic [ADDR_W-1:0]  r_fetch_addr;
    logic [IDX_W-1:0]   r_nib_idx;
    logic               r_inflight;
    logic [3:0]         r_pix;
    logic               r_underrun;

    logic [DATA_W-1:0]  w_head;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W:0]     w_pending;
    logic               w_need;
    logic               w_urgent;
    logic               w_run;
    logic               w_read;
    logic               w_write;
    logic               w_visible;
    logic               w_frame_end;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_flush;

    // Words already buffered plus the one possibly on its way back
    assign w_pending = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_need    = (w_pending < c_depth) && (r_fetch_addr < c_fb_words);
    assign w_urgent  = w_need && (w_pending < c_urgent);

    // Issue is combinational so a read returns in the very next clk; it is
    // gated by rst so the SRAM bus stays quiet while reset is held.
    assign w_run   = !rst && (r_state == RUN);
    assign w_read  = w_run && (w_urgent || (w_need && !bus.host_req));
    assign w_write = w_run && !w_urgent && bus.host_req;

    assign bus.mem_en    = w_read || w_write;
    assign bus.mem_we    = w_write;
    assign bus.mem_addr  = w_write ? bus.host_addr  :
                           w_read  ? r_fetch_addr   : '0;
    assign bus.mem_wdata = w_write ? bus.host_wdata : '0;
    assign bus.host_gnt  = w_write;

    assign w_visible   = (x < c_h_active) && (y < c_v_active);
    assign w_frame_end = (x == c_h_last) && (y == c_v_last);
    assign w_empty     = (w_count == '0);
    assign w_pop       = pixel_en && w_visible && !w_empty && (r_nib_idx == c_idx_last);

    // A return belonging to a read issued before FLUSH is dropped here
    assign w_push  = r_inflight && (r_state == RUN);
    assign w_flush = (r_state == FLUSH);

    vga_word_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (bus.mem_rdata),
        .pop   (w_pop),
        .flush (w_flush),
        .head  (w_head),
        .count (w_count)
    );

    // Frame FSM, fetch pointer and registered pixel/underrun outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RUN;
            r_fetch_addr <= '0;
            r_nib_idx    <= '0;
            r_inflight   <= 1'b0;
            r_pix        <= 4'd0;
            r_underrun   <= 1'b0;
        end else begin
            if (pixel_en) begin
                if (w_visible) begin
                    if (!w_empty) begin
                        r_pix     <= w_head[{r_nib_idx, 2'b00} +: 4];
                        r_nib_idx <= r_nib_idx + IDX_W'(1);
                    end else begin
                        r_pix      <= 4'd0;
                        r_underrun <= 1'b1;
                    end
                end else begin
                    r_pix <= 4'd0;
                end
            end

            case (r_state)
                RUN: begin
                    r_inflight <= w_read;
                    if (w_read) begin
                        r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
                    end
                    if (pixel_en && w_frame_end) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_inflight   <= 1'b0;
                    r_fetch_addr <= '0;
                    r_nib_idx    <= '0;
                    r_state      <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign pix_data = r_pix;
    assign underrun = r_underrun;
endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port framebuffer SRAM between two users: VGA scanout fetch and a host write port. Scanout gets 640x480, 4 bpp, with 4 pixels per 16-bit word, and holds a small prefetch FIFO. It takes the pixel enable and x/y counts from the VGA timing generator. It drives the SRAM and delivers one pixel nibble per pixel slot to the DAC/palette stage.

Parameters:
ADDR_W, 17, SRAM word address width (76800 words used)
DATA_W, 16, SRAM word width; 4 nibbles per word
FIFO_DEPTH, 4, prefetch FIFO depth in words (power of two)
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines
H_TOTAL, 800, pixel slots per line
V_TOTAL, 525, lines per frame

Ports:
clk  in  1  system clock; pixel rate is clk/4
rst  in  1  asynchronous, active-high reset
pixel_en  in  1  one-clk strobe per pixel slot (every 4th clk), from the timing generator
x  in  10  current pixel column, 0..H_TOTAL-1
y  in  10  current line, 0..V_TOTAL-1
host_req  in  1  host write request; held until granted
host_addr  in  ADDR_W  host write word address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  one-clk pulse: write issued this cycle
mem_en  out  1  SRAM access this cycle
mem_we  out  1  SRAM write (1) / read (0)
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  read data, valid exactly 1 clk after a read issue
pix_data  out  4  current pixel nibble
underrun  out  1  sticky: the FIFO was empty when a visible pixel needed data

Behaviour:
- Reset values: all outputs 0. FIFO is empty, fetch_addr=0, nibble index=0, in-flight flag=0, state=RUN.
- Frame restart: a pixel_en with x==H_TOTAL-1 and y==V_TOTAL-1 moves the FSM RUN->FLUSH for 1 clk.
  - FLUSH empties the FIFO and sets fetch_addr=0 and nibble index=0.
  - Any read return that arrives during or after FLUSH and was issued before it is discarded.
  - No SRAM access is issued in FLUSH. The FSM then returns to RUN.
- Fetch need: occupancy + inflight < FIFO_DEPTH and fetch_addr < 76800.
- Urgent: occupancy + inflight < 2.
- Arbitration, evaluated every clk in RUN, with at most one SRAM access per clk:
  - Urgent fetch -> issue a read at fetch_addr, then fetch_addr++.
  - Else if host_req -> issue a write at host_addr/host_wdata, host_gnt=1 in the same clk.
  - Else if fetch need -> issue a read.
  - Else mem_en=0.
- Read data is written into the FIFO in the clk after issue, and inflight clears then.
- Consumption on a pixel_en with x<H_ACTIVE and y<V_ACTIVE:
  - pix_data is registered and updated on that pixel_en.
  - If the FIFO is non-empty: pix_data = head word nibble[index], with index 0 = bits 3:0. Then index++; on index 3->0 the head word is popped.
  - If the FIFO is empty: pix_data=0, underrun is set, and index does not advance.
- On a pixel_en outside the visible area, pix_data=0.
- Simultaneous events: a FIFO push and pop in the same clk are both applied, and occupancy is unchanged. A pop never coincides with FLUSH (different x/y).
- Host starvation bound: scanout consumes 1 word per 16 clk, so a held host_req is granted within 3 clk in RUN.
- Host writes are blocked only during FLUSH and urgent fetches.
- Reset asserted mid-frame returns every register to its reset value immediately. Scanout resynchronises at the next frame restart; until then the FIFO refills from address 0.
- Address arithmetic: fetch_addr is unsigned ADDR_W. It saturates (stops fetching) at 76800 and never wraps.
- underrun clears only on rst.

Decomposition:
- Shared package vga_pkg holds:
  - H_ACTIVE, V_ACTIVE, H_TOTAL and V_TOTAL as constants, shared with the timing generator.
  - FB_WORDS = 76800 and PIX_PER_WORD = 4.
  - A state enum {RUN, FLUSH}.
- One natural sub-module: vga_word_fifo, a synchronous FIFO with push, pop, flush and an occupancy output.
- Arbitration and consumption stay in vga_fb_arbiter.

Test Plan:
- rst high then low, no host_req:
  - 4 reads are issued at addresses 0,1,2,3 in clks 1..4 after reset release, and mem_en then stays 0 until the first pop.
  - underrun=0 throughout the frame.
- FIFO pre-filled with word 0x4321 at visible x=0..3: pix_data sequence is 1,2,3,4, followed by nibbles from word 1.
- host_req held continuously through an active line:
  - host_gnt never gaps more than 3 clk.
  - All scanout reads still occur, and underrun stays 0.
- host_req raised in the same clk as an urgent fetch (occupancy 1): the read wins and host_gnt pulses in the next clk with mem_we=1 and the correct address/data.
- Frame restart with a read in flight: that data is discarded, the FIFO is empty after FLUSH, and the next read address is 0.
- SRAM model returning data late (bench forces occupancy 0 at a visible pixel): pix_data=0, underrun=1 and sticky until rst.
